// File: rtl/sfifo_rd_stream.sv
// sfifo_rd_stream: drains an sfifo with a registered read port and presents
// the words on a valid/ready stream. A 2-entry skid buffer together with a
// one-bit in-flight tracker sustains one word per cycle. The block never pops
// an empty FIFO and never pulls more words than the buffer can hold.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous reset, active-high
//   fifo_rempty  sfifo empty flag (registered inside the FIFO)
//   fifo_rdata   sfifo read data, valid the cycle after fifo_rinc
//   fifo_rinc    pop request to sfifo (combinational, gated by rst)
//   m_valid      output word available
//   m_ready      downstream accepts
//   m_data       output word, head of the skid buffer
//   word_cnt     accepted-word counter, 32 bits, wraps (only with
//                SFIFO_RD_CNT_EN defined)
//
// Build option: define SFIFO_RD_CNT_EN to compile in word_cnt.
module sfifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_rempty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef SFIFO_RD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inflight_q;
  logic             wptr_q;
  logic             rptr_q;
  logic [WIDTH-1:0] mem_q [SKID];

  logic             pop_c;
  logic [SUM_W-1:0] sum_c;

  // Occupancy after this cycle's pop, counting the word already requested.
  // A pop implies cnt_q >= 1, so the subtraction cannot underflow.
  always_comb begin
    pop_c = m_valid & m_ready;
    sum_c = SUM_W'(cnt_q) + SUM_W'(inflight_q) - SUM_W'(pop_c);
    cnt_d = cnt_q + CNT_W'(inflight_q) - CNT_W'(pop_c);
  end

  assign m_valid   = (cnt_q != '0);
  assign m_data    = mem_q[rptr_q];
  // Only request a word when a slot is guaranteed free on its arrival.
  assign fifo_rinc = !rst && !fifo_rempty && (sum_c < SUM_W'(SKID));

  // Skid buffer, pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      for (int i = 0; i < SKID; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= fifo_rinc;
      if (inflight_q) begin
        mem_q[wptr_q] <= fifo_rdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop_c) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef SFIFO_RD_CNT_EN
  logic [31:0] word_cnt_q;

  // Count accepted words; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (pop_c) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_sfifo_rd_stream.sv
// Bench for sfifo_rd_stream. A queue-based sfifo model feeds the DUT; a
// word-level model (queue of words landed in the skid buffer plus one
// in-flight flag) predicts m_valid/m_data/fifo_rinc, checked every cycle.
module tb_sfifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_rempty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rinc;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef SFIFO_RD_CNT_EN
  logic [31:0] word_cnt;
`endif

  sfifo_rd_stream #(.WIDTH(8), .SKID(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
`ifdef SFIFO_RD_CNT_EN
    ,
    .word_cnt    (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [7:0] fq[$];      // words sitting in the sfifo
  logic [7:0] landed[$];  // words held by the skid buffer, head first
  logic [7:0] got[$];     // words accepted downstream
  logic [7:0] sent[$];    // words pushed into the sfifo, in order
  logic       inflight_m = 1'b0;
  logic [7:0] inflight_word = 8'h00;
  logic       keep_fifo = 1'b0;
  logic       rst_seen = 1'b0;
  logic [31:0] acc_total = 32'd0;

  // Snapshot of the cycle's inputs/outputs, taken at negedge
  logic s_rst = 1'b1;
  logic s_rinc = 1'b0;
  logic s_pop = 1'b0;

  // Event counters used by directed tests
  int ncyc = 0;
  int rinc_count = 0;
  int valid_count = 0;
  int first_rinc_cyc = -1;
  int first_valid_cyc = -1;
  int last_valid_cyc = -1;
  logic [7:0] first_valid_data = 8'h00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // sfifo model and word-level skid model, advanced on each posedge
  always @(posedge clk) begin
    if (s_rst) begin
      if (!keep_fifo) fq.delete();
      landed.delete();
      inflight_m = 1'b0;
      acc_total  = 32'd0;
      rst_seen   = 1'b1;
      fifo_rempty <= (fq.size() == 0);
    end else begin
      if (s_pop) begin
        void'(landed.pop_front());
        acc_total = acc_total + 32'd1;
      end
      if (inflight_m) landed.push_back(inflight_word);
      inflight_m = s_rinc;
      if (s_rinc && fq.size() > 0) begin
        inflight_word = fq.pop_front();
        fifo_rdata <= inflight_word;
      end
      fifo_rempty <= (fq.size() == 0);
    end
  end

  // Per-cycle comparison against the model, sampled on negedge
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_pop;
    logic exp_rinc;
    int   occ;
    ncyc++;
    occ       = landed.size();
    exp_valid = (occ != 0);
    exp_pop   = exp_valid && m_ready;
    exp_rinc  = !rst && !fifo_rempty && ((occ + int'(inflight_m) - int'(exp_pop)) < 2);
    chk("rinc", 32'(fifo_rinc), 32'(exp_rinc));
    if (fifo_rinc && fifo_rempty) chk("rinc_when_empty", 32'(fifo_rinc), 32'd0);
    if (rst_seen) begin
      chk("valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) chk("data", 32'(m_data), 32'(landed[0]));
      if (occ + int'(inflight_m) > 2) chk("outstanding", 32'(occ + int'(inflight_m)), 32'd2);
`ifdef SFIFO_RD_CNT_EN
      chk("word_cnt", word_cnt, acc_total);
`endif
    end
    if (fifo_rinc) begin
      rinc_count++;
      if (first_rinc_cyc < 0) first_rinc_cyc = ncyc;
    end
    if (m_valid) begin
      valid_count++;
      if (first_valid_cyc < 0) begin
        first_valid_cyc  = ncyc;
        first_valid_data = m_data;
      end
      last_valid_cyc = ncyc;
    end
    if (m_valid && m_ready && !rst) got.push_back(m_data);
    s_rst  = rst;
    s_rinc = fifo_rinc;
    s_pop  = m_valid && m_ready && !rst;
  end

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [7:0] w);
    fq.push_back(w);
    sent.push_back(w);
  endtask

  task automatic clear_stats();
    got.delete();
    sent.delete();
    rinc_count = 0;
    valid_count = 0;
    first_rinc_cyc = -1;
    first_valid_cyc = -1;
    last_valid_cyc = -1;
  endtask

  task automatic drain(int k, int budget);
    for (int i = 0; i < budget && got.size() < k; i++) tick();
    chk("drain_count", 32'(got.size()), 32'(k));
  endtask

  task automatic check_order(string name);
    chk({name, "_len"}, 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      chk({name, "_word"}, 32'(got[i]), 32'(sent[i]));
  endtask

  initial begin
    // Test 1: reset values; rinc gated while rst holds even with a non-empty FIFO
    rst = 1'b1;
    tick(2);
    chk("rst_rinc", 32'(fifo_rinc), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    keep_fifo = 1'b1;
    fq.push_back(8'h77);
    tick(2);
    chk("rst_rempty_low", 32'(fifo_rempty), 32'd0);
    chk("rst_rinc_gated", 32'(fifo_rinc), 32'd0);
    tick(2);
    chk("rst_rinc_gated2", 32'(fifo_rinc), 32'd0);
    fq.delete();
    keep_fifo = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("idle_rinc", 32'(fifo_rinc), 32'd0);

    // Test 2: single word, two-edge latency, one valid cycle
    clear_stats();
    m_ready = 1'b1;
    push(8'hA5);
    tick(8);
    chk("single_rinc_pulses", 32'(rinc_count), 32'd1);
    chk("single_valid_cycles", 32'(valid_count), 32'd1);
    chk("single_latency", 32'(first_valid_cyc - first_rinc_cyc), 32'd2);
    chk("single_data", 32'(first_valid_data), 32'hA5);
    check_order("single");

    // Test 3: 20 words streaming, FIFO depth 16 refilled, no bubbles
    clear_stats();
    for (int i = 0; i < 16; i++) push(8'(i));
    tick(5);
    for (int i = 16; i < 20; i++) push(8'(i));
    drain(20, 100);
    tick(3);
    chk("stream_valid_cycles", 32'(valid_count), 32'd20);
    chk("stream_no_bubbles", 32'(last_valid_cyc - first_valid_cyc + 1), 32'd20);
    chk("stream_latency", 32'(first_valid_cyc - first_rinc_cyc), 32'd2);
    for (int i = 0; i < got.size(); i++) chk("stream_word", 32'(got[i]), 32'(i));

    // Test 4: backpressure with 5 queued words
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    tick(10);
    chk("bp_rinc_pulses", 32'(rinc_count), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data_held", 32'(m_data), 32'h30);
    m_ready = 1'b1;
    drain(5, 50);
    check_order("bp");

    // Test 5: random backpressure, 200 words
    clear_stats();
    begin
      int pushed = 0;
      for (int c = 0; c < 4000 && got.size() < 200; c++) begin
        m_ready = ($urandom_range(0, 2) != 0);
        if (pushed < 200 && fq.size() < 16 && $urandom_range(0, 3) != 0) begin
          push(8'($urandom_range(0, 255)));
          pushed++;
        end
        tick();
      end
      chk("rand_pushed", 32'(pushed), 32'd200);
    end
    chk("rand_count", 32'(got.size()), 32'd200);
    check_order("rand");

    // Test 6: reset with buffer full of outstanding words
    clear_stats();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    for (int i = 0; i < 20 && (landed.size() + int'(inflight_m)) < 2; i++) tick();
    chk("mid_outstanding", 32'(landed.size() + int'(inflight_m)), 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_rinc", 32'(fifo_rinc), 32'd0);
`ifdef SFIFO_RD_CNT_EN
    chk("mid_rst_word_cnt", word_cnt, 32'd0);
`endif
    rst = 1'b0;
    tick(3);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    chk("post_rst_rinc", 32'(fifo_rinc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
